// File: rtl/prbs7_checker.sv
// prbs7_checker: self-synchronising PRBS7 (x^7+x^6+1) bit-error-rate checker.
// Seeds a reference from the received stream, verifies it, then counts checked
// bits and errors while locked. Drops lock when the errors in one window get too dense.
module prbs7_checker #(
  parameter int unsigned LOCK_COUNT  = 32,
  parameter int unsigned WINDOW      = 128,
  parameter int unsigned UNLOCK_ERRS = 8,
  parameter int unsigned ERR_WIDTH   = 32,
  parameter int unsigned BIT_WIDTH   = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic                 data_in,
  input  logic                 clear,
  output logic                 lock,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [BIT_WIDTH-1:0] bit_count
);

  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                r_state;
  logic [6:0]            r_sr;
  logic [2:0]            r_seed_cnt;
  logic [MATCH_W-1:0]    r_match_cnt;
  logic [WIN_W-1:0]      r_win_cnt;
  logic [WERR_W-1:0]     r_win_errs;
  logic                  r_lock;
  logic                  r_err_pulse;
  logic [ERR_WIDTH-1:0]  r_err_count;
  logic [BIT_WIDTH-1:0]  r_bit_count;

  state_t                w_state_n;
  logic [6:0]            w_sr_n;
  logic [2:0]            w_seed_cnt_n;
  logic [MATCH_W-1:0]    w_match_cnt_n;
  logic [WIN_W-1:0]      w_win_cnt_n;
  logic [WERR_W-1:0]     w_win_errs_n;
  logic                  w_err_pulse_n;
  logic [ERR_WIDTH-1:0]  w_err_count_n;
  logic [BIT_WIDTH-1:0]  w_bit_count_n;
  logic                  w_pred;
  logic                  w_mismatch;

  assign w_pred     = r_sr[6] ^ r_sr[5];
  assign w_mismatch = data_in ^ w_pred;

  assign lock      = r_lock;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign bit_count = r_bit_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SEED;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state and next datapath values; everything holds unless valid
  always_comb begin
    w_state_n     = r_state;
    w_sr_n        = r_sr;
    w_seed_cnt_n  = r_seed_cnt;
    w_match_cnt_n = r_match_cnt;
    w_win_cnt_n   = r_win_cnt;
    w_win_errs_n  = r_win_errs;
    w_err_pulse_n = 1'b0;
    w_err_count_n = r_err_count;
    w_bit_count_n = r_bit_count;

    if (valid) begin
      case (r_state)
        ST_SEED: begin
          w_sr_n = {r_sr[5:0], data_in};
          if (r_seed_cnt != 3'd7) begin
            w_seed_cnt_n = r_seed_cnt + 3'd1;
          end
          // An all-zero reference would lock onto a stuck-at-0 line
          if ((w_seed_cnt_n == 3'd7) && (w_sr_n != 7'd0)) begin
            w_state_n = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          w_sr_n = {r_sr[5:0], data_in};
          if (!w_mismatch) begin
            w_match_cnt_n = r_match_cnt + MATCH_W'(1);
            if (w_match_cnt_n == MATCH_W'(LOCK_COUNT)) begin
              w_state_n     = ST_LOCKED;
              w_match_cnt_n = '0;
              w_win_cnt_n   = '0;
              w_win_errs_n  = '0;
            end
          end else begin
            // The mismatched bit stays in the reference as the first new seed bit
            w_state_n     = ST_SEED;
            w_seed_cnt_n  = 3'd1;
            w_match_cnt_n = '0;
          end
        end

        ST_LOCKED: begin
          // Free-running reference: received errors never enter the register
          w_sr_n        = {r_sr[5:0], w_pred};
          w_err_pulse_n = w_mismatch;
          if (r_bit_count != '1) begin
            w_bit_count_n = r_bit_count + BIT_WIDTH'(1);
          end
          if (w_mismatch && (r_err_count != '1)) begin
            w_err_count_n = r_err_count + ERR_WIDTH'(1);
          end
          w_win_cnt_n = r_win_cnt + WIN_W'(1);
          if (w_win_cnt_n == '0) begin
            w_win_errs_n = WERR_W'(w_mismatch);
          end else begin
            w_win_errs_n = r_win_errs + WERR_W'(w_mismatch);
          end
          if (w_win_errs_n >= WERR_W'(UNLOCK_ERRS)) begin
            w_state_n     = ST_SEED;
            w_seed_cnt_n  = 3'd0;
            w_match_cnt_n = '0;
            w_win_errs_n  = '0;
          end
        end

        default: begin
          w_state_n = ST_SEED;
        end
      endcase
    end

    // Clear wins over a same-cycle increment
    if (clear) begin
      w_err_count_n = '0;
      w_bit_count_n = '0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr        <= '0;
      r_seed_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_errs  <= '0;
      r_lock      <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_bit_count <= '0;
    end else begin
      r_sr        <= w_sr_n;
      r_seed_cnt  <= w_seed_cnt_n;
      r_match_cnt <= w_match_cnt_n;
      r_win_cnt   <= w_win_cnt_n;
      r_win_errs  <= w_win_errs_n;
      r_lock      <= (w_state_n == ST_LOCKED);
      r_err_pulse <= w_err_pulse_n;
      r_err_count <= w_err_count_n;
      r_bit_count <= w_bit_count_n;
    end
  end

endmodule

// File: tb/tb_prbs7_checker.sv
// tb_prbs7_checker: directed scenarios plus randomized stream against a behavioural model.
module tb_prbs7_checker;

  localparam int unsigned LOCK_COUNT  = 32;
  localparam int unsigned WINDOW      = 128;
  localparam int unsigned UNLOCK_ERRS = 8;
  localparam int unsigned ERR_WIDTH   = 32;
  localparam int unsigned BIT_WIDTH   = 48;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 valid;
  logic                 data_in;
  logic                 clear;
  logic                 lock;
  logic                 err_pulse;
  logic [ERR_WIDTH-1:0] err_count;
  logic [BIT_WIDTH-1:0] bit_count;

  prbs7_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .WINDOW     (WINDOW),
    .UNLOCK_ERRS(UNLOCK_ERRS),
    .ERR_WIDTH  (ERR_WIDTH),
    .BIT_WIDTH  (BIT_WIDTH)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (valid),
    .data_in  (data_in),
    .clear    (clear),
    .lock     (lock),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference sequence: b[n] = b[n-7] ^ b[n-6], seeded with seven ones (period 127)
  bit prbs  [0:126];
  bit flips [0:1199];
  int sidx;

  // Model state: mode 0 = hunting, 1 = verifying, 2 = locked
  int      m_mode, m_seed, m_match, m_win, m_werr;
  bit      m_ref[$];
  bit                   exp_lock, exp_pulse;
  logic [ERR_WIDTH-1:0] exp_err;
  logic [BIT_WIDTH-1:0] exp_bits;

  bit chk_en = 1'b0;
  bit seen_lock;
  int dut_pulses;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_mode = 0; m_seed = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_ref.delete();
    for (int i = 0; i < 7; i++) m_ref.push_back(1'b0);
    exp_lock = 0; exp_pulse = 0; exp_err = '0; exp_bits = '0;
  endfunction

  // One clock of the model, given the inputs sampled at that edge
  function automatic void model_step(input bit v, input bit d, input bit c);
    bit pred, e, nz;
    exp_pulse = 0;
    if (v) begin
      pred = m_ref[0] ^ m_ref[1];   // 7th and 6th most recent reference bits
      e = (d != pred);
      if (m_mode == 0) begin
        m_ref.push_back(d); void'(m_ref.pop_front());
        if (m_seed < 7) m_seed++;
        nz = 0;
        foreach (m_ref[i]) nz |= m_ref[i];
        if (m_seed == 7 && nz) m_mode = 1;
      end else if (m_mode == 1) begin
        m_ref.push_back(d); void'(m_ref.pop_front());
        if (!e) begin
          m_match++;
          if (m_match == LOCK_COUNT) begin
            m_mode = 2; m_match = 0; m_win = 0; m_werr = 0;
          end
        end else begin
          m_mode = 0; m_seed = 1; m_match = 0;
        end
      end else begin
        m_ref.push_back(pred); void'(m_ref.pop_front());
        exp_pulse = e;
        if (exp_bits != '1) exp_bits = exp_bits + 1;
        if (e && exp_err != '1) exp_err = exp_err + 1;
        m_win = (m_win + 1) % WINDOW;
        if (m_win == 0) m_werr = int'(e);
        else m_werr = m_werr + int'(e);
        if (m_werr >= UNLOCK_ERRS) begin
          m_mode = 0; m_seed = 0; m_match = 0; m_werr = 0;
        end
      end
    end
    if (c) begin
      exp_err  = '0;
      exp_bits = '0;
    end
    exp_lock = (m_mode == 2);
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("lock",      64'(lock),      64'(exp_lock));
      check("err_pulse", 64'(err_pulse), 64'(exp_pulse));
      check("err_count", 64'(err_count), 64'(exp_err));
      check("bit_count", 64'(bit_count), 64'(exp_bits));
      seen_lock |= lock;
      if (err_pulse) dut_pulses++;
    end
  end

  task automatic step(input bit v, input bit d, input bit c);
    valid = v; data_in = d; clear = c;
    @(posedge clk);
    model_step(v, d, c);
    #1;
    valid = 0; clear = 0;
  endtask

  task automatic do_reset();
    valid = 0; data_in = 0; clear = 0;
    rst_n = 0;
    model_reset();
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    sidx = 0;
    foreach (flips[i]) flips[i] = 0;
    seen_lock = 0;
    dut_pulses = 0;
  endtask

  // Send n stream bits, each valid with probability pct percent per cycle
  task automatic send(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      if (pct < 100) begin
        while ($urandom_range(99) >= pct) step(0, 1'($urandom_range(1)), 0);
      end
      step(1, prbs[sidx % 127] ^ flips[sidx], 0);
      sidx++;
    end
  endtask

  initial begin
    bit noise, v, d;
    for (int i = 0; i < 127; i++) prbs[i] = (i < 7) ? 1'b1 : (prbs[i-7] ^ prbs[i-6]);

    // Clean stream: lock after bit 39, 261 counted bits out of 300
    do_reset();
    check("rst_lock", 64'(lock), 64'd0);
    check("rst_bits", 64'(bit_count), 64'd0);
    send(38, 100);
    check("s1_lock_b38", 64'(lock), 64'd0);
    send(1, 100);
    check("s1_lock_b39", 64'(lock), 64'd1);
    send(261, 100);
    check("s1_bits", 64'(bit_count), 64'd261);
    check("s1_errs", 64'(err_count), 64'd0);

    // Single inverted bit: one error, no propagation
    do_reset();
    flips[99] = 1;
    send(300, 100);
    check("s2_errs",   64'(err_count), 64'd1);
    check("s2_pulses", 64'(dut_pulses), 64'd1);
    check("s2_lock",   64'(lock), 64'd1);
    check("s2_bits",   64'(bit_count), 64'd261);

    // Eight errors in one window drop lock, relock 39 bits later
    do_reset();
    for (int k = 0; k < 8; k++) flips[60 + 2*k] = 1;
    send(74, 100);
    check("s3_lock_7e", 64'(lock), 64'd1);
    check("s3_errs_7e", 64'(err_count), 64'd7);
    send(1, 100);
    check("s3_unlock",  64'(lock), 64'd0);
    check("s3_errs_8e", 64'(err_count), 64'd8);
    check("s3_bits",    64'(bit_count), 64'd36);
    send(38, 100);
    check("s3_relock_early", 64'(lock), 64'd0);
    send(1, 100);
    check("s3_relock",  64'(lock), 64'd1);
    check("s3_errs_kept", 64'(err_count), 64'd8);

    // Stuck-at-0 then stuck-at-1 never locks
    do_reset();
    for (int i = 0; i < 500; i++) step(1, 0, 0);
    for (int i = 0; i < 200; i++) step(1, 1, 0);
    check("s4_never_lock", 64'(seen_lock), 64'd0);
    check("s4_errs", 64'(err_count), 64'd0);
    check("s4_bits", 64'(bit_count), 64'd0);

    // Gapped valid (30%) behaves identically per valid bit
    do_reset();
    send(38, 30);
    check("s5_lock_b38", 64'(lock), 64'd0);
    send(1, 30);
    check("s5_lock_b39", 64'(lock), 64'd1);
    send(261, 30);
    check("s5_bits", 64'(bit_count), 64'd261);
    check("s5_errs", 64'(err_count), 64'd0);

    // Clear coincident with an errored bit, then async reset while locked
    do_reset();
    send(60, 100);
    check("s6_bits_pre", 64'(bit_count), 64'd21);
    step(1, prbs[sidx % 127] ^ 1'b1, 1);
    sidx++;
    check("s6_clr_errs", 64'(err_count), 64'd0);
    check("s6_clr_bits", 64'(bit_count), 64'd0);
    check("s6_clr_lock", 64'(lock), 64'd1);
    flips[65] = 1;
    send(10, 100);
    check("s6_errs_pre_rst", 64'(err_count), 64'd1);
    check("s6_bits_pre_rst", 64'(bit_count), 64'd10);
    @(posedge clk);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("s6_rst_lock", 64'(lock), 64'd0);
    check("s6_rst_errs", 64'(err_count), 64'd0);
    check("s6_rst_bits", 64'(bit_count), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // Randomized: gapped valid, sparse errors, noise bursts, occasional clear
    do_reset();
    noise = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(299) == 0) noise = ~noise;
      v = ($urandom_range(99) < 60);
      if (noise) d = 1'($urandom_range(1));
      else d = prbs[sidx % 127] ^ ($urandom_range(99) < 3);
      step(v, d, ($urandom_range(149) == 0));
      if (v) sidx++;
    end

    @(negedge clk);
    #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
